// File: rtl/btn_step_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// Module  : btn_step_ctrl
// Brief   : N-channel push-button debouncer with single/free-run/burst CPU
//           step generator driven by one selected channel.
// Rev     : 1.0 - initial release
// ----------------------------------------------------------------------------
module btn_step_ctrl #(
  parameter int N_BTN      = 4,
  parameter int DB_CYCLES  = 16,
  parameter int STEP_CH    = 0,
  parameter int RUN_PERIOD = 8,
  parameter int BURST_W    = 8,
  parameter int CNT_W      = 16
) (
  input  logic               CCLK,
  input  logic               RSTN,
  input  logic [N_BTN-1:0]   BTN_IN,
  input  logic [1:0]         MODE,
  input  logic [BURST_W-1:0] BURST_LEN,
  output logic [N_BTN-1:0]   BTN_LEVEL,
  output logic [N_BTN-1:0]   BTN_PRESS,
  output logic [N_BTN-1:0]   BTN_RELEASE,
  output logic               STEP,
  output logic               BUSY,
  output logic [CNT_W-1:0]   STEP_CNT
);

  localparam int DB_W  = $clog2(DB_CYCLES);
  localparam int PER_W = $clog2(RUN_PERIOD);
  localparam logic [DB_W-1:0]  c_DB_MAX  = DB_W'(DB_CYCLES - 1);
  localparam logic [PER_W-1:0] c_PER_MAX = PER_W'(RUN_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_BURST = 2'd2
  } state_t;

  logic [N_BTN-1:0]            r_sync1;
  logic [N_BTN-1:0]            r_sync2;
  logic [N_BTN-1:0]            r_level;
  logic [N_BTN-1:0]            r_press;
  logic [N_BTN-1:0]            r_release;
  logic [N_BTN-1:0][DB_W-1:0]  r_db_cnt;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PER_W-1:0]   r_per;
  logic [PER_W-1:0]   w_per_nxt;
  logic [BURST_W-1:0] r_rem;
  logic [BURST_W-1:0] w_rem_nxt;
  logic               r_step;
  logic               w_step_nxt;
  logic               r_busy;
  logic [CNT_W-1:0]   r_step_cnt;
  logic [1:0]         r_mode_prev;

  logic w_p;
  logic w_mode_chg;
  logic w_tick;

  // Press/release pulses are raised on the same edge that updates the level.
  always_ff @(posedge CCLK or negedge RSTN) begin
    if (!RSTN) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_db_cnt  <= '0;
    end else begin
      r_sync1   <= BTN_IN;
      r_sync2   <= r_sync1;
      r_press   <= '0;
      r_release <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == c_DB_MAX) begin
          r_level[i]   <= r_sync2[i];
          r_press[i]   <= r_sync2[i];
          r_release[i] <= ~r_sync2[i];
          r_db_cnt[i]  <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign w_p        = r_press[STEP_CH];
  assign w_mode_chg = (MODE != r_mode_prev);
  assign w_tick     = (r_per == c_PER_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_per_nxt   = r_per;
    w_rem_nxt   = r_rem;
    w_step_nxt  = 1'b0;
    if (w_mode_chg) begin
      w_state_nxt = S_IDLE;
      w_per_nxt   = '0;
      w_rem_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_per_nxt = '0;
          w_rem_nxt = '0;
          case (MODE)
            2'd1: begin
              if (w_p) begin
                w_state_nxt = S_RUN;
                w_step_nxt  = 1'b1;
              end
            end
            2'd2: begin
              // The first pulse is issued on entry, so it is already deducted.
              if (w_p && (BURST_LEN != '0)) begin
                w_step_nxt  = 1'b1;
                w_rem_nxt   = BURST_LEN - BURST_W'(1);
                w_state_nxt = (BURST_LEN == BURST_W'(1)) ? S_IDLE : S_BURST;
              end
            end
            default: begin
              w_step_nxt = w_p;
            end
          endcase
        end
        S_RUN: begin
          if (w_p) begin
            w_state_nxt = S_IDLE;
            w_per_nxt   = '0;
          end else if (w_tick) begin
            w_step_nxt = 1'b1;
            w_per_nxt  = '0;
          end else begin
            w_per_nxt = r_per + PER_W'(1);
          end
        end
        S_BURST: begin
          if (w_tick) begin
            w_step_nxt = 1'b1;
            w_per_nxt  = '0;
            w_rem_nxt  = r_rem - BURST_W'(1);
            if (r_rem == BURST_W'(1)) begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_per_nxt = r_per + PER_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_per_nxt   = '0;
          w_rem_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CCLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state     <= S_IDLE;
      r_per       <= '0;
      r_rem       <= '0;
      r_step      <= 1'b0;
      r_busy      <= 1'b0;
      r_step_cnt  <= '0;
      r_mode_prev <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_per       <= w_per_nxt;
      r_rem       <= w_rem_nxt;
      r_step      <= w_step_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_mode_prev <= MODE;
      if (w_step_nxt) begin
        r_step_cnt <= r_step_cnt + CNT_W'(1);
      end
    end
  end

  assign BTN_LEVEL   = r_level;
  assign BTN_PRESS   = r_press;
  assign BTN_RELEASE = r_release;
  assign STEP        = r_step;
  assign BUSY        = r_busy;
  assign STEP_CNT    = r_step_cnt;

endmodule
`default_nettype wire
